// File: rtl/itcm_uart_loader_if.sv
// ----------------------------------------------------------------------------
// itcm_uart_loader_if
//   Groups the two buses of the boot loader. The byte stream comes from UART0
//   receive and the write port goes to the ITCM BRAM.
//   master : environment side. Drives the received bytes and observes ITCM writes.
//   slave  : loader side. Consumes the bytes and drives the ITCM write port.
// Signals
//   rx_data    [7:0]        received UART byte
//   rx_valid                one-cycle strobe: rx_data is valid
//   itcm_we                 ITCM write enable, one-cycle pulse
//   itcm_addr  [ADDR_W-1:0] ITCM word address
//   itcm_wdata [31:0]       ITCM write data
// ----------------------------------------------------------------------------
interface itcm_uart_loader_if #(
    parameter int ADDR_W = 14
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              itcm_we;
    logic [ADDR_W-1:0] itcm_addr;
    logic [31:0]       itcm_wdata;

    modport master (
        output rx_data, rx_valid,
        input  itcm_we, itcm_addr, itcm_wdata
    );

    modport slave (
        input  rx_data, rx_valid,
        output itcm_we, itcm_addr, itcm_wdata
    );
endinterface

// File: rtl/itcm_uart_loader.sv
// ----------------------------------------------------------------------------
// itcm_uart_loader
//   Boot-time image loader. It parses a framed image from the UART0 byte
//   stream. The frame is MAGIC, CNT_LO, CNT_HI, then CNT*4 payload bytes
//   (LSB first), then an optional CSUM byte. Payload bytes are packed into
//   32-bit words and written to the ITCM from word 0 upward. The core is held
//   in reset until the image is complete and verified.
// Build option
//   LOADER_CHECKSUM_EN : when defined, a trailing CSUM byte is expected. It
//                        must equal the 8-bit sum of CNT_LO, CNT_HI and all
//                        payload bytes. When undefined, there is no CSUM byte
//                        and no sum logic is built.
// Ports
//   clk            system clock
//   rst            synchronous, active-high reset
//   bus            itcm_uart_loader_if.slave (rx byte stream in, ITCM write port out)
//   core_rst_hold  1 = keep the core in reset
//   load_done      image loaded and verified (sticky until rst)
//   load_err       frame error (sticky until the next MAGIC or rst)
// ----------------------------------------------------------------------------
module itcm_uart_loader #(
    parameter int         DEPTH       = 16384,
    parameter int         ADDR_W      = 14,
    parameter int         TIMEOUT_CYC = 50000000,
    parameter logic [7:0] MAGIC       = 8'hA5
) (
    input  logic                  clk,
    input  logic                  rst,
    itcm_uart_loader_if.slave     bus,
    output logic                  core_rst_hold,
    output logic                  load_done,
    output logic                  load_err
);

    localparam int            TO_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    // S_WLAST exists only in the checksum-less build. It gives the final write
    // pulse its own cycle before DONE is raised.
    typedef enum logic [2:0] {
        S_IDLE, S_LEN0, S_LEN1, S_DATA, S_CSUM, S_WLAST, S_DONE, S_ERR
    } state_t;

    state_t            r_state;
    logic [7:0]        r_cnt_lo;
    logic [15:0]       r_cnt;
    logic [1:0]        r_lane;
    logic [TO_W-1:0]   r_idle;
    logic              r_itcm_we;
    logic [ADDR_W-1:0] r_itcm_addr;
    logic [31:0]       r_itcm_wdata;
    logic              r_core_rst_hold;
    logic              r_load_done;
    logic              r_load_err;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        r_sum;
`endif

    logic              w_byte;
    logic [7:0]        w_rx;
    logic [16:0]       w_cnt_new;
    logic              w_last_word;
    logic              w_timed;

    assign w_byte      = bus.rx_valid;
    assign w_rx        = bus.rx_data;
    assign w_cnt_new   = {1'b0, w_rx, r_cnt_lo};
    assign w_last_word = (17'(r_itcm_addr) == (17'(r_cnt) - 17'd1));
    // The idle timer only runs while a frame is in flight.
    assign w_timed     = (r_state == S_LEN0) || (r_state == S_LEN1) ||
                         (r_state == S_DATA) || (r_state == S_CSUM) ||
                         (r_state == S_WLAST);

    assign bus.itcm_we    = r_itcm_we;
    assign bus.itcm_addr  = r_itcm_addr;
    assign bus.itcm_wdata = r_itcm_wdata;
    assign core_rst_hold  = r_core_rst_hold;
    assign load_done      = r_load_done;
    assign load_err       = r_load_err;

    // NOTE: every register here is written with <=. All reads see the values
    // from before the edge, so the order of the statements below only matters
    // where a later assignment deliberately overrides an earlier one.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_cnt_lo        <= '0;
            r_cnt           <= '0;
            r_lane          <= '0;
            r_idle          <= '0;
            r_itcm_we       <= 1'b0;
            r_itcm_addr     <= '0;
            r_itcm_wdata    <= '0;
            r_core_rst_hold <= 1'b1;
            r_load_done     <= 1'b0;
            r_load_err      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            r_sum           <= '0;
`endif
        end else begin
            // The write pulse lasts exactly one cycle and the address advances
            // right after it. The address saturates so that a full-depth image
            // cannot wrap it back to 0.
            if (r_itcm_we) begin
                r_itcm_we <= 1'b0;
                if (r_itcm_addr != '1)
                    r_itcm_addr <= r_itcm_addr + 1'b1;
            end

            // Idle timer. A byte arriving in the expiry cycle reloads the timer
            // and suppresses the error.
            if (w_timed) begin
                if (w_byte) begin
                    r_idle <= '0;
                end else if (r_idle == TO_LAST) begin
                    r_idle          <= '0;
                    r_state         <= S_ERR;
                    r_load_err      <= 1'b1;
                    r_core_rst_hold <= 1'b1;
                end else begin
                    r_idle <= r_idle + 1'b1;
                end
            end else begin
                r_idle <= '0;
            end

            case (r_state)
                S_IDLE, S_ERR: begin
                    if (w_byte && (w_rx == MAGIC)) begin
                        r_state     <= S_LEN0;
                        r_load_err  <= 1'b0;
                        r_itcm_addr <= '0;
                        r_lane      <= '0;
`ifdef LOADER_CHECKSUM_EN
                        r_sum       <= '0;
`endif
                    end
                end

                S_LEN0: begin
                    if (w_byte) begin
                        r_cnt_lo <= w_rx;
                        r_state  <= S_LEN1;
`ifdef LOADER_CHECKSUM_EN
                        r_sum    <= w_rx;
`endif
                    end
                end

                S_LEN1: begin
                    if (w_byte) begin
                        r_cnt  <= w_cnt_new[15:0];
                        r_lane <= '0;
`ifdef LOADER_CHECKSUM_EN
                        r_sum  <= r_sum + w_rx;
`endif
                        if (w_cnt_new > 17'(DEPTH)) begin
                            r_state    <= S_ERR;
                            r_load_err <= 1'b1;
                        end else if (w_cnt_new == '0) begin
`ifdef LOADER_CHECKSUM_EN
                            r_state         <= S_CSUM;
`else
                            r_state         <= S_DONE;
                            r_load_done     <= 1'b1;
                            r_core_rst_hold <= 1'b0;
`endif
                        end else begin
                            r_state <= S_DATA;
                        end
                    end
                end

                S_DATA: begin
                    if (w_byte) begin
                        r_itcm_wdata[8*r_lane +: 8] <= w_rx;
                        r_lane                      <= r_lane + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                        r_sum                       <= r_sum + w_rx;
`endif
                        if (r_lane == 2'd3) begin
                            r_itcm_we <= 1'b1;
                            if (w_last_word) begin
`ifdef LOADER_CHECKSUM_EN
                                r_state <= S_CSUM;
`else
                                r_state <= S_WLAST;
`endif
                            end
                        end
                    end
                end

`ifdef LOADER_CHECKSUM_EN
                S_CSUM: begin
                    if (w_byte) begin
                        if (w_rx == r_sum) begin
                            r_state         <= S_DONE;
                            r_load_done     <= 1'b1;
                            r_core_rst_hold <= 1'b0;
                        end else begin
                            r_state    <= S_ERR;
                            r_load_err <= 1'b1;
                        end
                    end
                end
`else
                S_WLAST: begin
                    r_state         <= S_DONE;
                    r_load_done     <= 1'b1;
                    r_core_rst_hold <= 1'b0;
                end
`endif

                default: ;  // S_DONE: terminal until rst
            endcase
        end
    end

endmodule

// File: tb/tb_itcm_uart_loader.sv
// ----------------------------------------------------------------------------
// tb_itcm_uart_loader
//   Directed and randomized frames sent to itcm_uart_loader. A monitor
//   records every ITCM write. The expected memory image and checksum are
//   computed from the frame contents.
// ----------------------------------------------------------------------------
module tb_itcm_uart_loader;

    localparam int ADDR_W = 14;
    localparam int TO     = 100;

    logic clk = 1'b0;
    logic rst;
    logic core_rst_hold, load_done, load_err;

    itcm_uart_loader_if #(.ADDR_W(ADDR_W)) bus ();

    itcm_uart_loader #(
        .DEPTH       (16384),
        .ADDR_W      (ADDR_W),
        .TIMEOUT_CYC (TO),
        .MAGIC       (8'hA5)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .core_rst_hold (core_rst_hold),
        .load_done     (load_done),
        .load_err      (load_err)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    logic [ADDR_W-1:0] mon_addr[$];
    logic [31:0]       mon_data[$];

    // The write pulse is one cycle wide, so each write is seen at exactly one negedge.
    always @(negedge clk) begin
        if (bus.itcm_we === 1'b1) begin
            mon_addr.push_back(bus.itcm_addr);
            mon_data.push_back(bus.itcm_wdata);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    endtask

    // Called at a negedge. Presents a byte for one cycle and returns at the
    // negedge right after the accepting posedge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) @(negedge clk);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    function automatic logic [7:0] model_sum(input logic [31:0] w[$]);
        int s;
        s = w.size() % 256 + (w.size() / 256) % 256;
        foreach (w[i]) for (int k = 0; k < 4; k++) s += (w[i] >> (8 * k)) & 32'hFF;
        return 8'(s % 256);
    endfunction

    // Header and payload only. The optional checksum byte is sent by finish_frame.
    task automatic send_frame(input logic [31:0] w[$], input int max_gap);
        int n;
        logic [31:0] word;
        n = w.size();
        send_byte(8'hA5, $urandom_range(max_gap, 0));
        send_byte(8'(n % 256), $urandom_range(max_gap, 0));
        send_byte(8'(n / 256), $urandom_range(max_gap, 0));
        foreach (w[i]) begin
            word = w[i];
            for (int k = 0; k < 4; k++)
                send_byte(8'((word >> (8 * k)) & 32'hFF), $urandom_range(max_gap, 0));
        end
    endtask

    task automatic finish_frame(input logic [31:0] w[$]);
`ifdef LOADER_CHECKSUM_EN
        send_byte(model_sum(w), 0);
`else
        if (w.size() > 0) @(negedge clk);  // let the final write pulse retire
`endif
    endtask

    task automatic check_load(input string tag, input logic [31:0] w[$]);
        check({tag, "_done"}, 32'(load_done), 32'd1);
        check({tag, "_err"}, 32'(load_err), 32'd0);
        check({tag, "_hold"}, 32'(core_rst_hold), 32'd0);
        check({tag, "_nwr"}, 32'(mon_addr.size()), 32'(w.size()));
        foreach (w[i]) begin
            if (i < mon_addr.size()) begin
                check($sformatf("%s_addr%0d", tag, i), 32'(mon_addr[i]), 32'(i));
                check($sformatf("%s_data%0d", tag, i), mon_data[i], w[i]);
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst          = 1'b1;
        bus.rx_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        mon_addr.delete();
        mon_data.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_we"}, 32'(bus.itcm_we), 32'd0);
        check({tag, "_addr"}, 32'(bus.itcm_addr), 32'd0);
        check({tag, "_wdata"}, bus.itcm_wdata, 32'd0);
        check({tag, "_hold"}, 32'(core_rst_hold), 32'd1);
        check({tag, "_done"}, 32'(load_done), 32'd0);
        check({tag, "_err"}, 32'(load_err), 32'd0);
    endtask

    initial begin
        logic [31:0] f1[$];
        logic [31:0] wr[$];
        logic [31:0] empty[$];

        rst          = 1'b1;
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        f1           = '{32'h0000_0013, 32'h0000_006F};

        // Reset state
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // Basic two-word image with back-to-back bytes and write timing
        send_frame(f1, 0);
        check("s1_we_pulse", 32'(bus.itcm_we), 32'd1);
        check("s1_we_addr", 32'(bus.itcm_addr), 32'd1);
        check("s1_done_early", 32'(load_done), 32'd0);
        @(negedge clk);
        check("s1_we_low", 32'(bus.itcm_we), 32'd0);
        check("s1_addr_inc", 32'(bus.itcm_addr), 32'd2);
`ifdef LOADER_CHECKSUM_EN
        send_byte(model_sum(f1), 0);
`endif
        check_load("s1", f1);
        // Bytes after DONE are ignored
        wr = '{32'hDEAD_BEEF};
        send_frame(wr, 1);
        finish_frame(wr);
        repeat (2) @(negedge clk);
        check_load("s1_post", f1);

`ifdef LOADER_CHECKSUM_EN
        // Bad checksum, then recovery on a good frame
        do_reset();
        send_frame(f1, 1);
        send_byte(model_sum(f1) + 8'd1, 0);
        check("s2_nwr", 32'(mon_addr.size()), 32'd2);
        check("s2_err", 32'(load_err), 32'd1);
        check("s2_hold", 32'(core_rst_hold), 32'd1);
        mon_addr.delete();
        mon_data.delete();
        wr = '{$urandom(), $urandom(), $urandom()};
        send_frame(wr, 2);
        finish_frame(wr);
        check_load("s2_recover", wr);
`endif

        // Garbage before MAGIC is dropped
        do_reset();
        send_byte(8'h00, 0);
        send_byte(8'hFF, 1);
        send_byte(8'h12, 0);
        send_frame(f1, 2);
        finish_frame(f1);
        check_load("s3", f1);

        // Count above depth: error right after LEN1, then MAGIC clears the error
        do_reset();
        send_byte(8'hA5, 0);
        send_byte(8'h01, 0);
        send_byte(8'h40, 0);
        check("s4_err", 32'(load_err), 32'd1);
        check("s4_hold", 32'(core_rst_hold), 32'd1);
        repeat (4) @(negedge clk);
        check("s4_nwr", 32'(mon_addr.size()), 32'd0);
        send_byte(8'hA5, 0);
        check("s4_err_clr", 32'(load_err), 32'd0);
        wr = '{$urandom(), $urandom()};
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        for (int i = 0; i < 2; i++)
            for (int k = 0; k < 4; k++) send_byte(8'((wr[i] >> (8 * k)) & 32'hFF), 0);
        finish_frame(wr);
        check_load("s4_recover", wr);

        // Zero-length image
        do_reset();
        send_frame(empty, 0);
        finish_frame(empty);
        check_load("s_cnt0", empty);

        // Timeout fires after exactly TO idle cycles with no write
        do_reset();
        send_byte(8'hA5, 0);
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'h13, 0);
        send_byte(8'h00, 0);
        repeat (TO - 1) @(negedge clk);
        check("s5_err_before", 32'(load_err), 32'd0);
        @(negedge clk);
        check("s5_err_at", 32'(load_err), 32'd1);
        check("s5_hold", 32'(core_rst_hold), 32'd1);
        check("s5_nwr", 32'(mon_addr.size()), 32'd0);

        // A byte in the expiry cycle wins
        do_reset();
        send_byte(8'hA5, 0);
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'h13, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, TO - 1);
        check("s5b_err", 32'(load_err), 32'd0);
        send_byte(8'h00, 0);
        wr = '{32'h0000_0013};
        finish_frame(wr);
        check_load("s5b", wr);

        // Reset in the middle of a word
        do_reset();
        send_byte(8'hA5, 0);
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("s6_rst");
        rst = 1'b0;
        repeat (8) @(negedge clk);
        check("s6_nwr", 32'(mon_addr.size()), 32'd0);
        wr = '{$urandom(), $urandom()};
        send_frame(wr, 1);
        finish_frame(wr);
        check_load("s6_fresh", wr);

        // Randomized images with random inter-byte gaps
        for (int r = 0; r < 4; r++) begin
            do_reset();
            wr.delete();
            for (int i = 0; i < $urandom_range(8, 1); i++) wr.push_back($urandom());
            send_frame(wr, 3);
            finish_frame(wr);
            check_load($sformatf("rand%0d", r), wr);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
